// File: rtl/can_crc15_chk.sv
// CAN CRC-15 receive checker: folds SOF..data bits into a CRC-15, captures the CRC field, reports match.
// Optional CRC-delimiter form check is built when CAN_CRC_DELIM_CHK_EN is defined.
module can_crc15_chk #(
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             abort,
    input  logic             bit_valid,
    input  logic             rx_bit,
    input  logic [CNT_W-1:0] crc_len,
    output logic             busy,
    output logic             crc_ok,
    output logic             crc_err,
`ifdef CAN_CRC_DELIM_CHK_EN
    output logic             form_err,
`endif
    output logic [14:0]      crc_calc,
    output logic [14:0]      crc_rx
);

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        CRCF,
`ifdef CAN_CRC_DELIM_CHK_EN
        DELIM,
`endif
        REPORT
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [3:0]       r_fld_cnt;
    logic [14:0]      r_crc_calc;
    logic [14:0]      r_crc_rx;
    logic             r_crc_ok;
    logic             r_crc_err;
`ifdef CAN_CRC_DELIM_CHK_EN
    logic             r_form_err;
`endif

    logic [CNT_W:0]   w_cnt_nxt;
    logic [CNT_W:0]   w_len_ext;
    logic [14:0]      w_crc_rx_nxt;
    logic             w_fld_last;

    function automatic logic [14:0] f_crc_step(input logic [14:0] crc, input logic b);
        logic fb;
        fb = b ^ crc[14];
        return {crc[13:0], 1'b0} ^ (fb ? 15'h4599 : 15'h0000);
    endfunction

    // One-wider sum so the end-of-data compare cannot wrap when crc_len is all-ones.
    assign w_cnt_nxt    = {1'b0, r_bit_cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign w_len_ext    = {1'b0, crc_len};
    assign w_crc_rx_nxt = {r_crc_rx[13:0], rx_bit};
    assign w_fld_last   = (r_fld_cnt == 4'd14);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_bit_cnt  <= '0;
            r_fld_cnt  <= '0;
            r_crc_calc <= '0;
            r_crc_rx   <= '0;
            r_crc_ok   <= 1'b0;
            r_crc_err  <= 1'b0;
`ifdef CAN_CRC_DELIM_CHK_EN
            r_form_err <= 1'b0;
`endif
        end else begin
            r_crc_ok  <= 1'b0;
            r_crc_err <= 1'b0;
`ifdef CAN_CRC_DELIM_CHK_EN
            r_form_err <= 1'b0;
`endif
            if (frame_start) begin
                r_fld_cnt <= '0;
                r_crc_rx  <= '0;
                r_state   <= DATA;
                if (bit_valid) begin
                    // The coincident bit is SOF, processed as bit 0 from a cleared CRC.
                    r_crc_calc <= f_crc_step(15'h0000, rx_bit);
                    r_bit_cnt  <= {{(CNT_W-1){1'b0}}, 1'b1};
                    if (w_len_ext <= {{CNT_W{1'b0}}, 1'b1})
                        r_state <= CRCF;
                end else begin
                    r_crc_calc <= '0;
                    r_bit_cnt  <= '0;
                end
            end else if (abort) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: ;
                    DATA: begin
                        if (bit_valid) begin
                            r_crc_calc <= f_crc_step(r_crc_calc, rx_bit);
                            if (!w_cnt_nxt[CNT_W])
                                r_bit_cnt <= w_cnt_nxt[CNT_W-1:0];
                            if (w_cnt_nxt >= w_len_ext)
                                r_state <= CRCF;
                        end
                    end
                    CRCF: begin
                        if (bit_valid) begin
                            r_crc_rx  <= w_crc_rx_nxt;
                            r_fld_cnt <= r_fld_cnt + 4'd1;
                            if (w_fld_last) begin
`ifdef CAN_CRC_DELIM_CHK_EN
                                r_state <= DELIM;
`else
                                // Compare against the field including this last bit so the
                                // result pulse coincides with the REPORT cycle.
                                r_state   <= REPORT;
                                r_crc_ok  <= (r_crc_calc == w_crc_rx_nxt);
                                r_crc_err <= (r_crc_calc != w_crc_rx_nxt);
`endif
                            end
                        end
                    end
`ifdef CAN_CRC_DELIM_CHK_EN
                    DELIM: begin
                        if (bit_valid) begin
                            r_state    <= REPORT;
                            r_crc_ok   <= (r_crc_calc == r_crc_rx);
                            r_crc_err  <= (r_crc_calc != r_crc_rx);
                            r_form_err <= ~rx_bit;
                        end
                    end
`endif
                    REPORT: r_state <= IDLE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign busy     = (r_state != IDLE);
    assign crc_ok   = r_crc_ok;
    assign crc_err  = r_crc_err;
`ifdef CAN_CRC_DELIM_CHK_EN
    assign form_err = r_form_err;
`endif
    assign crc_calc = r_crc_calc;
    assign crc_rx   = r_crc_rx;

endmodule

// File: tb/tb_can_crc15_chk.sv
// Directed bench for can_crc15_chk; builds with or without CAN_CRC_DELIM_CHK_EN.
module tb_can_crc15_chk;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic        abort = 1'b0;
    logic        bit_valid = 1'b0;
    logic        rx_bit = 1'b0;
    logic [6:0]  crc_len = 7'd0;
    logic        busy, crc_ok, crc_err;
    logic [14:0] crc_calc, crc_rx;
`ifdef CAN_CRC_DELIM_CHK_EN
    logic        form_err;
`endif

    int n_vec  = 0;
    int n_fail = 0;

    can_crc15_chk #(.CNT_W(7)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .abort(abort),
        .bit_valid(bit_valid), .rx_bit(rx_bit), .crc_len(crc_len),
        .busy(busy), .crc_ok(crc_ok), .crc_err(crc_err),
`ifdef CAN_CRC_DELIM_CHK_EN
        .form_err(form_err),
`endif
        .crc_calc(crc_calc), .crc_rx(crc_rx)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "bench watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("miscompare in %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bit_valid = 1'b1;
        rx_bit    = b;
        tick();
        bit_valid = 1'b0;
    endtask

    // Data bits go out from index nbits-1 down to 0, then the CRC field MSB first.
    task automatic run_frame(input logic [6:0] len, input int nbits, input logic [31:0] data,
                             input logic [14:0] crc, input logic delim);
        crc_len     = len;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int i = nbits - 1; i >= 0; i--) send_bit(data[i]);
        for (int i = 14; i >= 0; i--) send_bit(crc[i]);
`ifdef CAN_CRC_DELIM_CHK_EN
        send_bit(delim);
`endif
    endtask

    logic [14:0] c4599 = 15'h4599;
    logic        seen;

    initial begin
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_ok", 32'(crc_ok), 0);
        check("rst_err", 32'(crc_err), 0);
        check("rst_calc", 32'(crc_calc), 0);
        check("rst_rx", 32'(crc_rx), 0);

        // 19 zero bits leave the CRC at zero
        run_frame(7'd19, 19, 32'h0, 15'h0000, 1'b1);
        check("zeros_ok", 32'(crc_ok), 1);
        check("zeros_err", 32'(crc_err), 0);
        check("zeros_calc", 32'(crc_calc), 32'h0000);
`ifdef CAN_CRC_DELIM_CHK_EN
        check("zeros_form", 32'(form_err), 0);
`endif
        tick();

        // single bit 1 -> polynomial
        run_frame(7'd1, 1, 32'h1, 15'h4599, 1'b1);
        check("one_ok", 32'(crc_ok), 1);
        check("one_calc", 32'(crc_calc), 32'h4599);
        tick();
        check("one_pulse_width", 32'(crc_ok), 0);
        check("one_hold_calc", 32'(crc_calc), 32'h4599);
        check("one_idle", 32'(busy), 0);

        run_frame(7'd1, 1, 32'h1, 15'h4598, 1'b1);
        check("bad_err", 32'(crc_err), 1);
        check("bad_ok", 32'(crc_ok), 0);
        check("bad_rx", 32'(crc_rx), 32'h4598);
        tick();

        // bits 1,0: 0x4599 then shift with feedback -> 0x4EAB
        run_frame(7'd2, 2, 32'h2, 15'h4EAB, 1'b1);
        check("two_ok", 32'(crc_ok), 1);
        check("two_calc", 32'(crc_calc), 32'h4EAB);
        tick();

`ifdef CAN_CRC_DELIM_CHK_EN
        run_frame(7'd1, 1, 32'h1, 15'h4599, 1'b0);
        check("dlm_ok", 32'(crc_ok), 1);
        check("dlm_form", 32'(form_err), 1);
        tick();
`endif

        // frame_start together with bit_valid, crc_len 0
        crc_len     = 7'd0;
        frame_start = 1'b1;
        send_bit(1'b1);
        frame_start = 1'b0;
        check("fsbit_calc", 32'(crc_calc), 32'h4599);
        for (int i = 14; i >= 0; i--) send_bit(c4599[i]);
`ifdef CAN_CRC_DELIM_CHK_EN
        send_bit(1'b1);
`endif
        check("fsbit_ok", 32'(crc_ok), 1);
        tick();

        // abort after 5 data bits
        crc_len     = 7'd19;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        check("abort_busy_pre", 32'(busy), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", 32'(busy), 0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            send_bit(1'($urandom_range(0, 1)));
            seen = seen | crc_ok | crc_err | busy;
        end
        check("abort_quiet", 32'(seen), 0);

        // restart mid-CRC-field drops the frame
        crc_len     = 7'd1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        send_bit(1'b1);
        for (int i = 14; i >= 5; i--) send_bit(c4599[i]);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("restart_calc", 32'(crc_calc), 0);
        check("restart_rx", 32'(crc_rx), 0);
        check("restart_busy", 32'(busy), 1);
        send_bit(1'b1);
        for (int i = 14; i >= 0; i--) send_bit(c4599[i]);
`ifdef CAN_CRC_DELIM_CHK_EN
        send_bit(1'b1);
`endif
        check("restart_ok", 32'(crc_ok), 1);
        tick();

        // reset during the 8th CRC bit
        crc_len     = 7'd1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        send_bit(1'b1);
        for (int i = 14; i >= 8; i--) send_bit(c4599[i]);
        check("rst8_rx_pre", 32'(crc_rx), 32'h0045);
        bit_valid = 1'b1;
        rx_bit    = c4599[7];
        #2;
        rst = 1'b1;
        #1;
        check("rst8_busy", 32'(busy), 0);
        check("rst8_calc", 32'(crc_calc), 0);
        check("rst8_rx", 32'(crc_rx), 0);
        check("rst8_ok", 32'(crc_ok | crc_err), 0);
        bit_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check("rst8_after", 32'({busy, crc_ok, crc_err}), 0);
        run_frame(7'd1, 1, 32'h1, 15'h4599, 1'b1);
        check("rst8_next_ok", 32'(crc_ok), 1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/can_crc15_chk.md
CAN_CRC15_CHK -- requirements
Module: can_crc15_chk

Interface
REQ-001 SHALL have parameter: CNT_W, 7, width of bit counter and crc_len.
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: frame_start  input  1  one-cycle pulse, the current/next bit is SOF.
REQ-005 SHALL have port: abort  input  1  one-cycle pulse, drop frame (error frame, arbitration loss).
REQ-006 SHALL have port: bit_valid  input  1  strobe, rx_bit holds one destuffed sampled bit.
REQ-007 SHALL have port: rx_bit  input  1  received bit, 0 dominant.
REQ-008 SHALL have port: crc_len  input  CNT_W  bits covered by CRC, SOF through last data bit; stable before bit_cnt reaches it.
REQ-009 SHALL have port: busy  output  1  high in any state other than IDLE.
REQ-010 SHALL have port: crc_ok  output  1  one-cycle pulse, CRC match.
REQ-011 SHALL have port: crc_err  output  1  one-cycle pulse, CRC mismatch.
REQ-012 SHALL have port: form_err  output  1  one-cycle pulse, dominant CRC delimiter; exists only with macro.
REQ-013 SHALL have port: crc_calc  output  15  locally computed CRC.
REQ-014 SHALL have port: crc_rx  output  15  CRC field as received.

Function
REQ-015 SHALL have FSM states IDLE, DATA, CRCF, DELIM, REPORT.
REQ-016 SHALL, on frame_start in any state: clear crc_calc, crc_rx and bit_cnt, and go to DATA; a bit_valid in the same cycle is processed as bit 0 of DATA.
REQ-017 SHALL ignore bit_valid in IDLE when frame_start is low.
REQ-018 SHALL, in DATA on bit_valid: fb = rx_bit ^ crc_calc[14]; crc_calc = {crc_calc[13:0],0} ^ (fb ? 15'h4599 : 0); bit_cnt increments and saturates at all-ones.
REQ-019 SHALL go DATA->CRCF on the bit_valid where bit_cnt+1 >= crc_len, so crc_len 0 and 1 both end DATA after one bit.
REQ-020 SHALL, in CRCF on bit_valid: shift rx_bit into crc_rx, MSB first, with crc_calc frozen; after the 15th bit go to DELIM (macro defined) or REPORT (macro undefined).
REQ-021 SHALL, in DELIM on bit_valid: latch delimiter, go to REPORT.
REQ-022 SHALL, in REPORT (one cycle): crc_ok = (crc_calc == crc_rx), crc_err = its complement, form_err = latched delimiter == 0; then IDLE.
REQ-023 SHALL assert result pulses exactly one clk after the final accepted bit_valid; crc_ok and crc_err never together.
REQ-024 SHALL report form_err independently of the CRC compare; both may pulse in the same cycle.
REQ-025 SHALL, on abort: go to IDLE with no result pulse; when frame_start coincides with abort, frame_start wins.
REQ-026 SHALL, on frame_start mid-frame: restart per REQ-016 with no result pulse for the dropped frame.
REQ-027 SHALL hold crc_calc/crc_rx after REPORT until next frame_start or reset.

Reset
REQ-028 SHALL, on rst asserted at any time, including mid-frame: state IDLE; busy, crc_ok, crc_err, form_err = 0; crc_calc, crc_rx, bit_cnt = 0; effect immediate, no pending pulse after release.

Configuration
REQ-029 SHALL use macro CAN_CRC_DELIM_CHK_EN.
REQ-030 SHALL, with CAN_CRC_DELIM_CHK_EN defined: include DELIM state and form_err port, with results after the delimiter bit.
REQ-031 SHALL, with CAN_CRC_DELIM_CHK_EN undefined: omit DELIM and form_err, with results one clk after the 15th CRC bit.

Verification
REQ-032 SHALL cover: crc_len=19, 19 zero bits, CRC 0x0000, delimiter 1 -> crc_ok=1, crc_calc=0x0000.
REQ-033 SHALL cover: crc_len=1, bit 1, CRC 0x4599, delimiter 1 -> crc_ok=1, crc_calc=0x4599.
REQ-034 SHALL cover: as REQ-033 but CRC 0x4598 -> crc_err=1, crc_rx=0x4598, crc_ok=0.
REQ-035 SHALL cover (macro defined): as REQ-033 but delimiter 0 -> crc_ok=1 and form_err=1 in same cycle.
REQ-036 SHALL cover: abort after 5 data bits -> busy=0 next clk, no pulses for 40 further bit_valids.
REQ-037 SHALL cover: rst during 8th CRC bit -> all outputs 0 at once; next frame per REQ-033 -> crc_ok=1.
